// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction fetch / program-flow stage: PC, IR and NZP codes.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic [19:0] imem_rdata,
  input  logic        imem_valid,
  output logic [19:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        exec_done,
  input  logic        redirect_jump,
  input  logic        redirect_branch,
  input  logic [19:0] redirect_offset,
  input  logic        cc_write,
  input  logic [19:0] cc_value,
  output logic [11:0] pc,
  output logic [2:0]  cc_nzp,
  output logic [15:0] retired_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t      state_q;
  logic [11:0] pc_q;
  logic [19:0] instr_q;
  logic [2:0]  cc_nzp_q;
  logic [15:0] retired_q;

  logic        w_taken;
  logic [11:0] w_pc_seq;
  logic [11:0] w_pc_d;
  logic [2:0]  w_cc_d;
  logic        w_n;
  logic        w_z;

  // Branch qualification deliberately uses the pre-update condition codes.
  assign w_taken  = redirect_jump | (redirect_branch & (|(instr_q[19:17] & cc_nzp_q)));
  assign w_pc_seq = pc_q + 12'd1;
  assign w_pc_d   = w_taken ? (w_pc_seq + redirect_offset[11:0]) : w_pc_seq;

  assign w_n    = cc_value[19];
  assign w_z    = (cc_value == 20'd0);
  assign w_cc_d = {w_n, w_z, ~w_n & ~w_z};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 20'd0;
      cc_nzp_q  <= 3'b010;
      retired_q <= 16'd0;
    end else begin
      if (cc_write) begin
        cc_nzp_q <= w_cc_d;
      end
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            instr_q <= imem_rdata;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            pc_q      <= w_pc_d;
            retired_q <= retired_q + 16'd1;
            state_q   <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_req      = (state_q == S_FETCH);
  assign instr_valid   = (state_q == S_ISSUE);
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instruction   = instr_q;
  assign cc_nzp        = cc_nzp_q;
  assign retired_count = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed self-checking bench for fetch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [19:0] imem_rdata;
  logic        imem_valid;
  logic [19:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        exec_done;
  logic        redirect_jump;
  logic        redirect_branch;
  logic [19:0] redirect_offset;
  logic        cc_write;
  logic [19:0] cc_value;
  logic [11:0] pc;
  logic [2:0]  cc_nzp;
  logic [15:0] retired_count;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_pc;
  logic [15:0] exp_ret;

  fetch_sequencer #(.RESET_PC(12'h000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_valid      (imem_valid),
    .instruction     (instruction),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .exec_done       (exec_done),
    .redirect_jump   (redirect_jump),
    .redirect_branch (redirect_branch),
    .redirect_offset (redirect_offset),
    .cc_write        (cc_write),
    .cc_value        (cc_value),
    .pc              (pc),
    .cc_nzp          (cc_nzp),
    .retired_count   (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Starts at a negedge in FETCH, ends at a negedge in EXEC.
  task automatic fetch_issue(input logic [19:0] ins, input int fwait, input int rwait);
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, exp_pc);
    repeat (fwait) begin
      imem_valid = 1'b0;
      imem_rdata = 20'h5A5A5;
      @(negedge clk);
      chk("wait_req", imem_req, 1);
      chk("wait_ivalid", instr_valid, 0);
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 20'hBAD00;
    chk("issue_ivalid", instr_valid, 1);
    chk("issue_req", imem_req, 0);
    chk("issue_instr", instruction, ins);
    repeat (rwait) begin
      instr_ready = 1'b0;
      @(negedge clk);
      chk("hold_ivalid", instr_valid, 1);
      chk("hold_instr", instruction, ins);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("exec_ivalid", instr_valid, 0);
    chk("exec_req", imem_req, 0);
  endtask

  task automatic exec(input logic jmp, input logic br, input logic [19:0] off,
                      input logic ccw, input logic [19:0] ccv,
                      input logic [11:0] next_pc, input logic [2:0] next_cc);
    exec_done       = 1'b1;
    redirect_jump   = jmp;
    redirect_branch = br;
    redirect_offset = off;
    cc_write        = ccw;
    cc_value        = ccv;
    @(negedge clk);
    exec_done       = 1'b0;
    redirect_jump   = 1'b0;
    redirect_branch = 1'b0;
    redirect_offset = 20'd0;
    cc_write        = 1'b0;
    exp_pc  = next_pc;
    exp_ret = exp_ret + 16'd1;
    chk("next_pc", pc, exp_pc);
    chk("next_addr", imem_addr, exp_pc);
    chk("retired", retired_count, exp_ret);
    chk("cc_after_exec", cc_nzp, next_cc);
    chk("back_to_fetch", imem_req, 1);
  endtask

  // One FETCH cycle without memory data; exec_done/jump must be ignored here.
  task automatic idle_cc(input logic ccw, input logic [19:0] ccv, input logic [2:0] exp_cc);
    cc_write      = ccw;
    cc_value      = ccv;
    exec_done     = 1'b1;
    redirect_jump = 1'b1;
    redirect_offset = 20'h00007;
    @(negedge clk);
    cc_write      = 1'b0;
    exec_done     = 1'b0;
    redirect_jump = 1'b0;
    redirect_offset = 20'd0;
    chk("idle_cc", cc_nzp, exp_cc);
    chk("idle_pc", pc, exp_pc);
    chk("idle_ret", retired_count, exp_ret);
    chk("idle_req", imem_req, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_rdata = 20'd0;
    imem_valid = 1'b0;
    instr_ready = 1'b0;
    exec_done = 1'b0;
    redirect_jump = 1'b0;
    redirect_branch = 1'b0;
    redirect_offset = 20'd0;
    cc_write = 1'b0;
    cc_value = 20'd0;
    exp_pc = 12'h000;
    exp_ret = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, 12'h000);
    chk("rst_instr", instruction, 20'h0);
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_pc", pc, 12'h000);
    chk("rst_cc", cc_nzp, 3'b010);
    chk("rst_ret", retired_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Straight-line, zero-wait: pc 0 -> 1 -> 2 -> 3
    fetch_issue(20'h01111, 0, 0); exec(0, 0, 20'd0, 0, 20'd0, 12'h001, 3'b010);
    fetch_issue(20'h02222, 0, 0); exec(0, 0, 20'd0, 0, 20'd0, 12'h002, 3'b010);
    fetch_issue(20'h03333, 0, 0); exec(0, 0, 20'd0, 0, 20'd0, 12'h003, 3'b010);
    chk("retired_3", retired_count, 16'd3);

    // Memory wait states and issue backpressure
    fetch_issue(20'h04444, 4, 2); exec(0, 0, 20'd0, 0, 20'd0, 12'h004, 3'b010);
    fetch_issue(20'h05555, 0, 0); exec(0, 0, 20'd0, 0, 20'd0, 12'h005, 3'b010);

    // Branch qualification at pc=5 with cc=N
    idle_cc(1, 20'h80000, 3'b100);
    fetch_issue(20'h80000, 0, 0); exec(0, 1, 20'h00003, 0, 20'd0, 12'h009, 3'b100);
    fetch_issue(20'h40000, 0, 0); exec(0, 1, 20'h00003, 0, 20'd0, 12'h00A, 3'b100);

    // Jump to 0x010, then jump by -16 to 0x001
    fetch_issue(20'h00000, 0, 0); exec(1, 0, 20'h00005, 0, 20'd0, 12'h010, 3'b100);
    fetch_issue(20'h00000, 0, 0); exec(1, 0, 20'hFFFF0, 0, 20'd0, 12'h001, 3'b100);

    // Reach 0xFFF then wrap to 0
    fetch_issue(20'h00000, 0, 0); exec(1, 0, 20'h00FFD, 0, 20'd0, 12'hFFF, 3'b100);
    fetch_issue(20'h00000, 0, 0); exec(0, 0, 20'd0, 0, 20'd0, 12'h000, 3'b100);

    // Jump and non-matching branch together: jump wins
    fetch_issue(20'h20000, 0, 0); exec(1, 1, 20'h00004, 0, 20'd0, 12'h005, 3'b100);

    // Branch uses old cc (P) while cc_write of 0 lands on the same edge
    idle_cc(1, 20'h00005, 3'b001);
    fetch_issue(20'h20000, 0, 0); exec(0, 1, 20'h00002, 1, 20'h00000, 12'h008, 3'b010);
    // cc=Z, branch on N|P not taken
    fetch_issue(20'hA0000, 0, 0); exec(0, 1, 20'h0000A, 0, 20'd0, 12'h009, 3'b010);
    // cc_write while in ISSUE/EXEC still updates
    fetch_issue(20'h00001, 0, 1); exec(0, 0, 20'd0, 1, 20'hFFFFF, 12'h00A, 3'b100);

    // Asynchronous reset while in EXEC
    fetch_issue(20'h0ABCD, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ivalid", instr_valid, 0);
    chk("arst_req", imem_req, 1);
    chk("arst_pc", pc, 12'h000);
    chk("arst_instr", instruction, 20'h0);
    chk("arst_cc", cc_nzp, 3'b010);
    chk("arst_ret", retired_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 12'h000;
    exp_ret = 16'd0;
    @(negedge clk);
    fetch_issue(20'h07777, 1, 0); exec(0, 0, 20'd0, 0, 20'd0, 12'h001, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
